// File: rtl/ram_tx_reader.sv
// Drains bytes from the RX buffer RAM into a dv/done style UART transmitter.
// Optional build macro RAM_TX_READER_CRLF_EN inserts an LF after every transmitted CR.
module ram_tx_reader #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [ADDR_W-1:0] wr_ptr,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              tx_dv,
  output logic [DATA_W-1:0] tx_byte,
  input  logic              tx_done,
  output logic              empty,
  output logic [ADDR_W-1:0] pending,
  output logic              busy
);

`ifdef RAM_TX_READER_CRLF_EN
  typedef enum logic [2:0] {IDLE, FETCH, SEND, WAIT_DONE, LF_SEND} state_t;
  localparam logic [DATA_W-1:0] CHAR_CR = DATA_W'(8'h0D);
  localparam logic [DATA_W-1:0] CHAR_LF = DATA_W'(8'h0A);
  logic lf_flag;
`else
  typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT_DONE} state_t;
`endif

  state_t            state;
  logic [ADDR_W-1:0] rd_ptr;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return p + ADDR_W'(1);
  endfunction

  // Modular pointer difference; the writer keeps one slot free so equality means empty.
  assign ram_rd_addr = rd_ptr;
  assign empty       = (wr_ptr == rd_ptr);
  assign pending     = wr_ptr - rd_ptr;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rd_ptr  <= '0;
      tx_dv   <= 1'b0;
      tx_byte <= '0;
`ifdef RAM_TX_READER_CRLF_EN
      lf_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
`ifdef RAM_TX_READER_CRLF_EN
          lf_flag <= 1'b0;
`endif
          if (enable && !empty) state <= FETCH;
        end
        // RAM was addressed with rd_ptr on the previous edge, so ram_dout is valid here.
        FETCH: begin
          tx_byte <= ram_dout;
          tx_dv   <= 1'b1;
          rd_ptr  <= ptr_inc(rd_ptr);
          state   <= SEND;
        end
        SEND: begin
          tx_dv <= 1'b0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx_done) begin
`ifdef RAM_TX_READER_CRLF_EN
            if (tx_byte == CHAR_CR && !lf_flag) begin
              tx_byte <= CHAR_LF;
              tx_dv   <= 1'b1;
              lf_flag <= 1'b1;
              state   <= LF_SEND;
            end else begin
              state <= IDLE;
            end
`else
            state <= IDLE;
`endif
          end
        end
`ifdef RAM_TX_READER_CRLF_EN
        LF_SEND: begin
          tx_dv <= 1'b0;
          state <= WAIT_DONE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_tx_reader.sv
// Scoreboard bench for ram_tx_reader: RAM, writer pointer and transmitter are modelled here.
module tb_ram_tx_reader;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       enable = 1'b0;
  logic [8:0] wr_ptr = '0;
  logic [8:0] ram_rd_addr;
  logic [7:0] ram_dout;
  logic       tx_dv;
  logic [7:0] tx_byte;
  logic       tx_done = 1'b0;
  logic       empty;
  logic [8:0] pending;
  logic       busy;

  ram_tx_reader #(.ADDR_W(9), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .wr_ptr(wr_ptr),
    .ram_rd_addr(ram_rd_addr), .ram_dout(ram_dout), .tx_dv(tx_dv),
    .tx_byte(tx_byte), .tx_done(tx_done), .empty(empty),
    .pending(pending), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         lf;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] ram [512];
  logic [8:0] mrd = '0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         wr_cyc = 0;
  int         done_cyc = 0;
  int         tx_lat = 20;
  int         dv_count = 0;
  int         n_gap = 0;
  bit         chk_gap = 1'b0;
  logic       prev_dv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_dout <= ram[ram_rd_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp_v, $time);
    end
  endtask

  task automatic put_byte(input logic [7:0] b, input logic [8:0] a);
    ram[a] = b;
    exp_q.push_back('{b, 1'b0});
`ifdef RAM_TX_READER_CRLF_EN
    if (b == 8'h0D) exp_q.push_back('{8'h0A, 1'b1});
`endif
  endtask

  task automatic wait_idle(input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && empty) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain_timeout", {31'd0, ok}, 32'd1);
  endtask

  // Transmitter model: tx_done pulses tx_lat cycles after each tx_dv, regardless of reset.
  initial begin
    forever begin
      @(negedge clk);
      while (tx_dv) begin
        repeat (tx_lat) @(negedge clk);
        tx_done  = 1'b1;
        done_cyc = cyc;
        @(negedge clk);
        tx_done  = 1'b0;
      end
    end
  end

  // Monitor: every tx_dv pops one expected byte; consumed non-LF bytes advance the model pointer.
  always @(negedge clk) begin
    if (rst_n && tx_dv) begin
      chk("dv_width", {31'd0, prev_dv}, 32'd0);
      chk("queue_nonempty", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("tx_byte", {24'd0, tx_byte}, {24'd0, e.b});
        if (!e.lf) mrd = mrd + 9'd1;
        chk("rd_addr", {23'd0, ram_rd_addr}, {23'd0, mrd});
        chk("pending", {23'd0, pending}, {23'd0, 9'(wr_ptr - mrd)});
      end
      if (chk_gap) begin
        if (n_gap == 0) chk("first_latency", cyc - wr_cyc, 2);
        else            chk("done_to_dv_gap", cyc - done_cyc, 3);
        n_gap++;
      end
      dv_count++;
    end
    prev_dv = tx_dv;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    bit seen;
    logic [7:0] b;
    foreach (ram[i]) ram[i] = 8'h00;

    // Reset values, and combinational empty/pending while in reset
    #1 rst_n = 1'b0;
    wr_ptr = 9'd5;
    repeat (3) @(negedge clk);
    chk("rst_tx_dv", {31'd0, tx_dv}, 32'd0);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_addr", {23'd0, ram_rd_addr}, 32'd0);
    chk("rst_pending5", {23'd0, pending}, 32'd5);
    chk("rst_empty0", {31'd0, empty}, 32'd0);
    wr_ptr = 9'd0;
    #1;
    chk("rst_pending0", {23'd0, pending}, 32'd0);
    chk("rst_empty1", {31'd0, empty}, 32'd1);
    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
    repeat (3) @(negedge clk);

    // Three bytes with latency and byte-to-byte gap checks
    tx_lat  = 20;
    chk_gap = 1'b1;
    put_byte(8'h0F, 9'd0);
    put_byte(8'hAA, 9'd1);
    put_byte(8'h80, 9'd2);
    wr_ptr = 9'd3;
    wr_cyc = cyc;
    wait_idle(400);
    chk_gap = 1'b0;
    chk("a_count", dv_count, 3);
    chk("a_empty", {31'd0, empty}, 32'd1);
    chk("a_busy", {31'd0, busy}, 32'd0);
    chk("a_rd_addr", {23'd0, ram_rd_addr}, 32'd3);

    // Random bursts up to address 510, with varying transmitter latency
    while (wr_ptr != 9'd510) begin
      n = $urandom_range(1, 8);
      if (n > 510 - int'(wr_ptr)) n = 510 - int'(wr_ptr);
      for (int k = 0; k < n; k++) put_byte(8'($urandom), wr_ptr + 9'(k));
      tx_lat = $urandom_range(1, 4);
      wr_ptr = wr_ptr + 9'(n);
      repeat ($urandom_range(0, 30)) @(negedge clk);
    end
    wait_idle(6000);
    chk("bulk_rd_addr", {23'd0, ram_rd_addr}, 32'd510);

    // Wrap-around 510, 511, 0
    tx_lat = 6;
    put_byte(8'h11, 9'd510);
    put_byte(8'h22, 9'd511);
    put_byte(8'h33, 9'd0);
    wr_ptr = 9'd1;
    #1;
    chk("wrap_pending3", {23'd0, pending}, 32'd3);
    wait_idle(200);
    chk("wrap_rd_addr", {23'd0, ram_rd_addr}, 32'd1);

    // enable dropped one cycle after the first tx_dv of four pending bytes
    tx_lat = 5;
    base = dv_count;
    for (int k = 0; k < 4; k++) begin
      b = 8'($urandom);
      if (b == 8'h0D) b = 8'h0E;
      put_byte(b, 9'd1 + 9'(k));
    end
    @(negedge clk);
    wr_ptr = 9'd5;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_dv) begin
        seen = 1'b1;
        break;
      end
    end
    chk("en_first_dv", {31'd0, seen}, 32'd1);
    @(negedge clk);
    enable = 1'b0;
    for (int i = 0; i < 100 && busy; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("en_off_count", dv_count - base, 1);
    chk("en_off_pending", {23'd0, pending}, 32'd3);
    chk("en_off_busy", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    wait_idle(300);
    chk("en_on_count", dv_count - base, 4);

    // Asynchronous reset while waiting for tx_done
    tx_lat = 20;
    put_byte(8'h5A, 9'd5);
    put_byte(8'hA5, 9'd6);
    wr_ptr = 9'd7;
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (tx_dv) begin
        seen = 1'b1;
        break;
      end
    end
    chk("rst_mid_dv_seen", {31'd0, seen}, 32'd1);
    repeat (3) @(negedge clk);
    #2;
    rst_n  = 1'b0;
    wr_ptr = 9'd0;
    exp_q.delete();
    mrd = '0;
    #1;
    chk("arst_tx_dv", {31'd0, tx_dv}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_rd_addr", {23'd0, ram_rd_addr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base  = dv_count;
    repeat (40) @(negedge clk);
    chk("stray_done_dv", dv_count - base, 0);
    chk("stray_done_busy", {31'd0, busy}, 32'd0);

    // CR handling: LF inserted only in the CRLF build
    tx_lat = 4;
    base = dv_count;
    put_byte(8'h41, 9'd0);
    put_byte(8'h0D, 9'd1);
    put_byte(8'h42, 9'd2);
    wr_ptr = 9'd3;
    wait_idle(300);
    chk("cr_rd_addr", {23'd0, ram_rd_addr}, 32'd3);
`ifdef RAM_TX_READER_CRLF_EN
    chk("cr_count", dv_count - base, 4);
`else
    chk("cr_count", dv_count - base, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
